monster_fire_scheduler: RTL and testbench
=========================================

// Module: monster_fire_scheduler
// PURPOSE
//  Arbiter deciding which monster fires each frame and which shared missile slot carries the shot.
//  Replaces free-running per-monster fire timers with one scheduler.
//  Inputs: per-monster alive mask and missile-slot busy mask.
//  Outputs: at most one one-hot fire pulse per frame, paired with a one-hot slot grant.
//  Sits between the monster array (alive/deactivated flags) and a shared monster-missile pool.
// PARAMETERS
//  MONSTER_AMOUNT        16  number of requesters (monsters)
//  SLOT_AMOUNT           4   shared missile slots
//  PER_MONSTER_COOLDOWN  60  enabled frames between two shots of the same monster (1..2^CNT_W-1)
//  GLOBAL_COOLDOWN       12  enabled frames between any two shots (1..2^CNT_W-1)
//  CNT_W                 8   cooldown counter width
// PORTS
//  clk         in   1               system clock
//  resetN      in   1               asynchronous active-low reset
//  enable      in   1               game running; low freezes counters and blocks firing
//  startOfFrame in  1               one-cycle frame strobe
//  wave_reset  in   1               synchronous clear at start of a new wave
//  alive       in   MONSTER_AMOUNT  1 = monster may fire (not hit, not deactivated)
//  slot_busy   in   SLOT_AMOUNT     1 = missile slot currently in flight
//  fire_pulse  out  MONSTER_AMOUNT  one-hot, one-cycle: this monster fires now
//  slot_grant  out  SLOT_AMOUNT     one-hot, one-cycle, coincident with fire_pulse: slot to launch
// BEHAVIOUR
//  Reset values: fire_pulse=0, slot_grant=0, all counters=0, rr pointer=0, state=IDLE.
//  FSM: IDLE -> DECR -> ARB -> IDLE.
//   IDLE: leave on startOfFrame&enable; otherwise hold.
//   DECR: one cycle. Every nonzero per-monster counter and the global counter decrement by 1, saturating at 0.
//   ARB: one cycle. Computes and registers the outputs.
//  Latency: strobe sampled at cycle T -> DECR at T+1 -> ARB at T+2 -> outputs high during T+3 only.
//  Eligible set, evaluated in ARB: alive[i] & (cnt[i]==0).
//  Fire occurs only if all of:
//   - global counter == 0
//   - at least one eligible monster
//   - at least one slot with slot_busy==0
//  Monster choice: round-robin, first eligible index strictly after the last granted index, wrapping at MONSTER_AMOUNT-1 -> 0.
//  Slot choice: lowest-index free slot.
//  On fire:
//   - cnt[winner] <= PER_MONSTER_COOLDOWN
//   - global <= GLOBAL_COOLDOWN
//   - pointer <= winner
//  No fire: outputs stay 0, counters and pointer unchanged.
//  Guarantees: at most one shot per frame; same monster at most once per PER_MONSTER_COOLDOWN enabled frames.
//  startOfFrame arriving in DECR/ARB is ignored (no queuing).
//  enable low: IDLE not left. If enable falls in DECR/ARB, the sequence completes but ARB suppresses the fire.
//  alive/slot_busy are sampled in ARB only; a monster that dies after ARB still has its pulse delivered (consumer masks it).
//  wave_reset:
//   - clears counters and pointer, sets state=IDLE, outputs 0 next cycle
//   - dominates a simultaneous startOfFrame
//  alive==0 (all dead): never fires; counters still decrement.
//  Asynchronous reset mid-sequence: immediate return to reset values, no partial pulse.
// STRUCTURE
//  monster_sched_pkg: state_t enum {IDLE,DECR,ARB}; function first_free(slot_busy) -> one-hot.
//  Sub-module rr_arbiter #(N): inputs req[N], ptr (clog2 N); outputs grant one-hot, grant_idx, valid. Purely combinational.
//  Top: FSM, counter array, global counter, output registers.
// TESTING (bench params: MONSTER_AMOUNT=4, SLOT_AMOUNT=2, PER_MONSTER_COOLDOWN=5, GLOBAL_COOLDOWN=2)
//  1. Reset, alive=4'b1111, slot_busy=0, enable=1, strobe every 10 cycles.
//     -> frame1 fire_pulse=0010 (pointer 0 -> next index 1), slot_grant=01, exactly 3 cycles after the strobe, 1 cycle wide.
//  2. Continue test 1 over 12 frames.
//     -> fires in frames 1,3,5,7,9,11; monsters 1,2,3,0,1,2; never two shots within 2 frames.
//  3. alive=0001, others as test 1.
//     -> monster0 fires in frames 1,6,11 (every 5th frame); other frames outputs stay 0.
//  4. slot_busy=01 -> slot_grant=10.
//     slot_busy=11 -> no fire, and the cooldown counters are not reloaded.
//  5. enable=0 for 3 frames mid-run -> no pulses, counters frozen; resumed timing is shifted by exactly 3 frames.
//  6. wave_reset together with startOfFrame, and resetN low during ARB.
//     -> no pulse issued; next enabled frame fires monster1 (pointer=0).

Source files
------------

// File: rtl/monster_sched_pkg.sv
// ---------------------------------------------------------------------------
// monster_sched_pkg
// Shared types and helpers for the monster fire scheduler.
//   state_t    : scheduler FSM states (IDLE, DECR, ARB)
//   MAX_SLOTS  : widest missile-slot mask first_free() can handle
//   first_free : one-hot of the lowest-index clear bit of a busy mask
// ---------------------------------------------------------------------------
package monster_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DECR = 2'd1,
        ARB  = 2'd2
    } state_t;

    localparam int MAX_SLOTS = 32;

    // Lowest clear bit isolated: ~x & (x + 1). All-busy wraps x+1 to zero,
    // so the result is 0 when no slot is free.
    function automatic logic [MAX_SLOTS-1:0] first_free(input logic [MAX_SLOTS-1:0] busy);
        return ~busy & (busy + MAX_SLOTS'(1));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first asserted request strictly after
// ptr_i, wrapping N-1 -> 0. Requires N >= 2.
//   req_i       in  N      request vector
//   ptr_i       in  PTR_W  index of the last granted requester
//   grant_o     out N      one-hot grant (0 when no request)
//   grant_idx_o out PTR_W  binary index of the grant
//   valid_o     out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 16,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] grant_idx_o,
    output logic             valid_o
);

    int               pos;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        pos         = 0;
        idx         = '0;
        // Offset N lands back on ptr_i itself, so the last granted
        // requester is only chosen when it is the sole one asking.
        for (int k = 1; k <= N; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = PTR_W'(pos);
            if (!valid_o && req_i[idx]) begin
                valid_o     = 1'b1;
                grant_idx_o = idx;
            end
        end
        if (valid_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/monster_fire_scheduler.sv
// ---------------------------------------------------------------------------
// monster_fire_scheduler
// Once per enabled frame, picks at most one monster to fire (round-robin over
// those alive and off cooldown) and pairs it with the lowest free missile
// slot. Outputs are registered one-cycle pulses, three cycles after the
// frame strobe is sampled.
//   clk            in   1               system clock
//   resetN         in   1               asynchronous active-low reset
//   enable_i       in   1               game running; low freezes and blocks firing
//   startOfFrame_i in   1               one-cycle frame strobe
//   wave_reset_i   in   1               synchronous clear for a new wave
//   alive_i        in   MONSTER_AMOUNT  monster may fire
//   slot_busy_i    in   SLOT_AMOUNT     missile slot in flight
//   fire_pulse_o   out  MONSTER_AMOUNT  one-hot fire pulse
//   slot_grant_o   out  SLOT_AMOUNT     one-hot slot grant, with fire_pulse_o
//
// state | meaning
// IDLE  | wait for an enabled frame strobe
// DECR  | decrement nonzero cooldown counters
// ARB   | pick monster and slot, register pulses, reload cooldowns
// ---------------------------------------------------------------------------
module monster_fire_scheduler
    import monster_sched_pkg::*;
#(
    parameter int MONSTER_AMOUNT       = 16,
    parameter int SLOT_AMOUNT          = 4,
    parameter int PER_MONSTER_COOLDOWN = 60,
    parameter int GLOBAL_COOLDOWN      = 12,
    parameter int CNT_W                = 8
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      enable_i,
    input  logic                      startOfFrame_i,
    input  logic                      wave_reset_i,
    input  logic [MONSTER_AMOUNT-1:0] alive_i,
    input  logic [SLOT_AMOUNT-1:0]    slot_busy_i,
    output logic [MONSTER_AMOUNT-1:0] fire_pulse_o,
    output logic [SLOT_AMOUNT-1:0]    slot_grant_o
);

    localparam int MON_W = $clog2(MONSTER_AMOUNT);

    state_t                                   state_q, state_d;
    logic [MONSTER_AMOUNT-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]                         glob_q, glob_d;
    logic [MON_W-1:0]                         ptr_q, ptr_d;
    logic [MONSTER_AMOUNT-1:0]                fire_q, fire_d;
    logic [SLOT_AMOUNT-1:0]                   grant_q, grant_d;

    logic [MONSTER_AMOUNT-1:0]                eligible;
    logic [MONSTER_AMOUNT-1:0]                arb_grant;
    logic [MON_W-1:0]                         arb_idx;
    logic                                     arb_valid;
    logic [MAX_SLOTS-1:0]                     busy_pad;
    logic [MAX_SLOTS-1:0]                     free_oh;
    logic                                     slot_avail;

    always_comb begin
        for (int i = 0; i < MONSTER_AMOUNT; i++) begin
            eligible[i] = alive_i[i] && (cnt_q[i] == '0);
        end
        // Slots beyond SLOT_AMOUNT read as busy so they are never chosen.
        busy_pad                  = '1;
        busy_pad[SLOT_AMOUNT-1:0] = slot_busy_i;
        free_oh                   = first_free(busy_pad);
        slot_avail                = |free_oh;
    end

    rr_arbiter #(
        .N     (MONSTER_AMOUNT),
        .PTR_W (MON_W)
    ) u_rr_arbiter (
        .req_i       (eligible),
        .ptr_i       (ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .valid_o     (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        glob_d  = glob_q;
        ptr_d   = ptr_q;
        fire_d  = '0;
        grant_d = '0;

        unique case (state_q)
            IDLE: begin
                if (startOfFrame_i && enable_i) begin
                    state_d = DECR;
                end
            end
            DECR: begin
                state_d = ARB;
                if (enable_i) begin
                    for (int i = 0; i < MONSTER_AMOUNT; i++) begin
                        if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end
                    end
                    if (glob_q != '0) begin
                        glob_d = glob_q - CNT_W'(1);
                    end
                end
            end
            ARB: begin
                state_d = IDLE;
                if (enable_i && (glob_q == '0) && arb_valid && slot_avail) begin
                    fire_d         = arb_grant;
                    grant_d        = free_oh[SLOT_AMOUNT-1:0];
                    cnt_d[arb_idx] = CNT_W'(PER_MONSTER_COOLDOWN);
                    glob_d         = CNT_W'(GLOBAL_COOLDOWN);
                    ptr_d          = arb_idx;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wave_reset_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            glob_d  = '0;
            ptr_d   = '0;
            fire_d  = '0;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            glob_q  <= '0;
            ptr_q   <= '0;
            fire_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            glob_q  <= glob_d;
            ptr_q   <= ptr_d;
            fire_q  <= fire_d;
            grant_q <= grant_d;
        end
    end

    assign fire_pulse_o = fire_q;
    assign slot_grant_o = grant_q;

endmodule

// File: tb/tb_monster_fire_scheduler.sv
module tb_monster_fire_scheduler;

    localparam int MA = 4;
    localparam int SA = 2;

    logic          clk = 1'b0;
    logic          resetN;
    logic          enable;
    logic          sof;
    logic          wr;
    logic [MA-1:0] alive;
    logic [SA-1:0] busy;
    logic [MA-1:0] fire;
    logic [SA-1:0] grant;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    monster_fire_scheduler #(
        .MONSTER_AMOUNT       (MA),
        .SLOT_AMOUNT          (SA),
        .PER_MONSTER_COOLDOWN (5),
        .GLOBAL_COOLDOWN      (2),
        .CNT_W                (8)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .enable_i       (enable),
        .startOfFrame_i (sof),
        .wave_reset_i   (wr),
        .alive_i        (alive),
        .slot_busy_i    (busy),
        .fire_pulse_o   (fire),
        .slot_grant_o   (grant)
    );

    typedef struct {
        logic          rst;
        logic [MA-1:0] alive;
        logic [SA-1:0] busy;
        logic          en;
        logic [MA-1:0] ef;
        logic [SA-1:0] eg;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [MA-1:0] a, input logic [SA-1:0] b,
                                input logic e, input logic [MA-1:0] f, input logic [SA-1:0] g);
        vec_t v;
        v.rst = r; v.alive = a; v.busy = b; v.en = e; v.ef = f; v.eg = g;
        vq.push_back(v);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        resetN = 1'b0;
        sof    = 1'b0;
        wr     = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    // One 10-cycle frame. Strobe driven at the first negedge; the pulse is
    // expected on the 3rd following negedge, anything else nonzero is stray.
    // rst_cyc/drop_cyc (0 = unused) pull resetN low or drop enable at that negedge.
    task automatic do_frame(input logic [MA-1:0] a, input logic [SA-1:0] b, input logic e,
                            input logic w, input int rst_cyc, input int drop_cyc,
                            output logic [MA-1:0] f3, output logic [SA-1:0] g3, output int stray);
        @(negedge clk);
        alive  = a;
        busy   = b;
        enable = e;
        sof    = 1'b1;
        wr     = w;
        f3     = '0;
        g3     = '0;
        stray  = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 3) begin
                f3 = fire;
                g3 = grant;
            end else if (fire != '0 || grant != '0) begin
                stray++;
            end
            if (c == 1) begin
                sof = 1'b0;
                wr  = 1'b0;
            end
            if (rst_cyc != 0 && c == rst_cyc)      resetN = 1'b0;
            if (rst_cyc != 0 && c == rst_cyc + 2)  resetN = 1'b1;
            if (drop_cyc != 0 && c == drop_cyc)    enable = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [MA-1:0] f;
        logic [SA-1:0] g;
        int            s;

        // All monsters alive: fires every other frame, round-robin 1,2,3,0,1,2.
        add(1, 4'b1111, 2'b00, 1, 4'b0010, 2'b01);
        add(0, 4'b1111, 2'b00, 1, 4'b0000, 2'b00);
        add(0, 4'b1111, 2'b00, 1, 4'b0100, 2'b01);
        add(0, 4'b1111, 2'b00, 1, 4'b0000, 2'b00);
        add(0, 4'b1111, 2'b00, 1, 4'b1000, 2'b01);
        add(0, 4'b1111, 2'b00, 1, 4'b0000, 2'b00);
        add(0, 4'b1111, 2'b00, 1, 4'b0001, 2'b01);
        add(0, 4'b1111, 2'b00, 1, 4'b0000, 2'b00);
        add(0, 4'b1111, 2'b00, 1, 4'b0010, 2'b01);
        add(0, 4'b1111, 2'b00, 1, 4'b0000, 2'b00);
        add(0, 4'b1111, 2'b00, 1, 4'b0100, 2'b01);
        add(0, 4'b1111, 2'b00, 1, 4'b0000, 2'b00);
        // Only monster 0 alive: fires frames 1, 6, 11.
        add(1, 4'b0001, 2'b00, 1, 4'b0001, 2'b01);
        for (int i = 2; i <= 5; i++) add(0, 4'b0001, 2'b00, 1, 4'b0000, 2'b00);
        add(0, 4'b0001, 2'b00, 1, 4'b0001, 2'b01);
        for (int i = 7; i <= 10; i++) add(0, 4'b0001, 2'b00, 1, 4'b0000, 2'b00);
        add(0, 4'b0001, 2'b00, 1, 4'b0001, 2'b01);
        // Slot selection; all-busy frame must not reload the global cooldown.
        add(1, 4'b1111, 2'b01, 1, 4'b0010, 2'b10);
        add(0, 4'b1111, 2'b00, 1, 4'b0000, 2'b00);
        add(0, 4'b1111, 2'b11, 1, 4'b0000, 2'b00);
        add(0, 4'b1111, 2'b00, 1, 4'b0100, 2'b01);
        add(0, 4'b1111, 2'b10, 1, 4'b0000, 2'b00);
        add(0, 4'b1111, 2'b10, 1, 4'b1000, 2'b01);
        // Enable low for frames 4..6: the frame-6 shot moves to frame 9.
        add(1, 4'b0001, 2'b00, 1, 4'b0001, 2'b01);
        add(0, 4'b0001, 2'b00, 1, 4'b0000, 2'b00);
        add(0, 4'b0001, 2'b00, 1, 4'b0000, 2'b00);
        add(0, 4'b0001, 2'b00, 0, 4'b0000, 2'b00);
        add(0, 4'b0001, 2'b00, 0, 4'b0000, 2'b00);
        add(0, 4'b0001, 2'b00, 0, 4'b0000, 2'b00);
        add(0, 4'b0001, 2'b00, 1, 4'b0000, 2'b00);
        add(0, 4'b0001, 2'b00, 1, 4'b0000, 2'b00);
        add(0, 4'b0001, 2'b00, 1, 4'b0001, 2'b01);
        add(0, 4'b0001, 2'b00, 1, 4'b0000, 2'b00);

        resetN = 1'b0;
        enable = 1'b1;
        sof    = 1'b0;
        wr     = 1'b0;
        alive  = 4'b1111;
        busy   = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_fire", 32'(fire), 32'h0);
        check("reset_grant", 32'(grant), 32'h0);
        resetN = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_strobe_fire", 32'(fire), 32'h0);

        foreach (vq[i]) begin
            if (vq[i].rst) apply_reset();
            do_frame(vq[i].alive, vq[i].busy, vq[i].en, 1'b0, 0, 0, f, g, s);
            check($sformatf("vec%0d_fire", i), 32'(f), 32'(vq[i].ef));
            check($sformatf("vec%0d_grant", i), 32'(g), 32'(vq[i].eg));
            check($sformatf("vec%0d_stray", i), 32'(s), 32'd0);
        end

        // wave_reset with the strobe: no pulse, then pointer restarts at 0.
        apply_reset();
        do_frame(4'b1111, 2'b00, 1, 1'b0, 0, 0, f, g, s);
        do_frame(4'b1111, 2'b00, 1, 1'b0, 0, 0, f, g, s);
        do_frame(4'b1111, 2'b00, 1, 1'b0, 0, 0, f, g, s);
        check("wave_pre_fire", 32'(f), 32'h4);
        do_frame(4'b1111, 2'b00, 1, 1'b1, 0, 0, f, g, s);
        check("wave_frame_fire", 32'(f), 32'h0);
        check("wave_frame_stray", 32'(s), 32'd0);
        do_frame(4'b1111, 2'b00, 1, 1'b0, 0, 0, f, g, s);
        check("wave_next_fire", 32'(f), 32'h2);
        check("wave_next_grant", 32'(g), 32'h1);

        // resetN low during ARB: no pulse, then pointer restarts at 0.
        apply_reset();
        do_frame(4'b1111, 2'b00, 1, 1'b0, 0, 0, f, g, s);
        check("arst_f1_fire", 32'(f), 32'h2);
        do_frame(4'b1111, 2'b00, 1, 1'b0, 0, 0, f, g, s);
        do_frame(4'b1111, 2'b00, 1, 1'b0, 2, 0, f, g, s);
        check("arst_frame_fire", 32'(f), 32'h0);
        check("arst_frame_stray", 32'(s), 32'd0);
        do_frame(4'b1111, 2'b00, 1, 1'b0, 0, 0, f, g, s);
        check("arst_next_fire", 32'(f), 32'h2);
        check("arst_next_grant", 32'(g), 32'h1);

        // Enable drops while in DECR: sequence completes without a shot.
        apply_reset();
        do_frame(4'b1111, 2'b00, 1, 1'b0, 0, 1, f, g, s);
        check("endrop_fire", 32'(f), 32'h0);
        check("endrop_stray", 32'(s), 32'd0);
        do_frame(4'b1111, 2'b00, 1, 1'b0, 0, 0, f, g, s);
        check("endrop_next_fire", 32'(f), 32'h2);
        check("endrop_next_grant", 32'(g), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
